// File: rtl/multdiv_sequencer_if.sv
// Bundles the ALU-side start/result handshake and the shared-adder bus of multdiv_sequencer.
// slave = the sequencer; master = the pipeline plus the external adder.
interface multdiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_mult;
  logic             ctrl_div;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_sub;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_mult, ctrl_div, data_operandA, data_operandB, add_sum, add_cout,
    input  add_a, add_b, add_sub, data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_mult, ctrl_div, data_operandA, data_operandB, add_sum, add_cout,
    output add_a, add_b, add_sub, data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply/divide sequencer driving an external shared adder, one op per cycle.
// Optional macro MULTDIV_DIV0_FAST_EN: divide by zero detected at start jumps straight to DONE.
module multdiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic                clock,
  input logic                reset_n,
  multdiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEGA,
    S_NEGB,
    S_ITER,
    S_NEGR,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_absA;
  logic [WIDTH-1:0] r_absB;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;
  logic             r_isMult;
  logic             r_neg;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_rdy;

  logic             w_start;
  logic             w_div0Fast;
  logic [WIDTH-1:0] w_remShift;
  logic [WIDTH-1:0] w_absB;
  logic             w_multExc;
  logic             w_divZero;
  logic             w_divOvf;
  logic             w_exc;
  logic [WIDTH-1:0] w_addA;
  logic [WIDTH-1:0] w_addB;
  logic             w_addSub;

  assign w_start = bus.ctrl_mult | bus.ctrl_div;

`ifdef MULTDIV_DIV0_FAST_EN
  assign w_div0Fast = bus.ctrl_div && !bus.ctrl_mult && (bus.data_operandB == '0);
`else
  assign w_div0Fast = 1'b0;
`endif

  // Restoring-division partial remainder shifted left with the next dividend bit.
  assign w_remShift = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_absB     = r_opB[WIDTH-1] ? bus.add_sum : r_opB;

  assign w_multExc = r_neg ? ((|r_hi) || (r_lo[WIDTH-1] && (|r_lo[WIDTH-2:0])))
                           : ((|r_hi) || r_lo[WIDTH-1]);
  assign w_divZero = (r_absB == '0);
  assign w_divOvf  = (r_opA == MIN_NEG) && (r_opB == '1);
  assign w_exc     = r_isMult ? w_multExc : (w_divZero || w_divOvf);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A start in any state restarts the sequence, silently dropping an operation in flight.
  always_comb begin
    w_next = r_state;
    if (w_start) begin
      w_next = w_div0Fast ? S_DONE : S_NEGA;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_IDLE;
        S_NEGA:  w_next = S_NEGB;
        S_NEGB:  w_next = S_ITER;
        S_ITER:  w_next = (r_cnt == CW'(WIDTH - 1)) ? S_NEGR : S_ITER;
        S_NEGR:  w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_addA   = '0;
    w_addB   = '0;
    w_addSub = 1'b0;
    case (r_state)
      S_NEGA: begin
        w_addB   = r_opA;
        w_addSub = 1'b1;
      end
      S_NEGB: begin
        w_addB   = r_opB;
        w_addSub = 1'b1;
      end
      S_ITER: begin
        if (r_isMult) begin
          w_addA = r_hi;
          w_addB = r_lo[0] ? r_absA : '0;
        end else begin
          w_addA   = w_remShift;
          w_addB   = r_absB;
          w_addSub = 1'b1;
        end
      end
      S_NEGR: begin
        w_addB   = r_lo;
        w_addSub = r_neg;
      end
      default: ;
    endcase
  end

  // r_hi/r_lo hold {P_hi, P_lo} for multiply and {remainder, quotient} for divide.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_opA    <= '0;
      r_opB    <= '0;
      r_absA   <= '0;
      r_absB   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_isMult <= 1'b0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_start) begin
      r_opA    <= bus.data_operandA;
      r_opB    <= bus.data_operandB;
      r_isMult <= bus.ctrl_mult;
      r_cnt    <= '0;
      if (w_div0Fast) begin
        r_result <= '0;
        r_exc    <= 1'b1;
      end
    end else begin
      case (r_state)
        S_NEGA: begin
          r_absA <= r_opA[WIDTH-1] ? bus.add_sum : r_opA;
        end
        S_NEGB: begin
          r_absB <= w_absB;
          r_neg  <= r_opA[WIDTH-1] ^ r_opB[WIDTH-1];
          r_hi   <= '0;
          r_lo   <= r_isMult ? w_absB : r_absA;
          r_cnt  <= '0;
        end
        S_ITER: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_isMult) begin
            r_hi <= {bus.add_cout, bus.add_sum[WIDTH-1:1]};
            r_lo <= {bus.add_sum[0], r_lo[WIDTH-1:1]};
          end else begin
            r_hi <= bus.add_cout ? bus.add_sum : w_remShift;
            r_lo <= {r_lo[WIDTH-2:0], bus.add_cout};
          end
        end
        S_NEGR: begin
          r_result <= (!r_isMult && w_divZero) ? '0 : bus.add_sum;
          r_exc    <= w_exc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdy <= 1'b0;
    end else begin
      r_rdy <= (r_state == S_DONE);
    end
  end

  assign bus.add_a          = w_addA;
  assign bus.add_b          = w_addB;
  assign bus.add_sub        = w_addSub;
  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = r_rdy;
  assign bus.busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: behavioural adder, scoreboard queue of expected results,
// independent 64-bit reference model for the randomized operations.
module tb_multdiv_sequencer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  multdiv_sequencer_if #(.WIDTH(32)) ifc ();

  multdiv_sequencer #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  // Behavioural stand-in for the shared adder; carry-out 1 on subtract means no borrow.
  logic [32:0] addFull;
  always_comb begin
    addFull = ifc.add_sub ? ({1'b0, ifc.add_a} + {1'b0, ~ifc.add_b} + 33'd1)
                          : ({1'b0, ifc.add_a} + {1'b0, ifc.add_b});
  end
  assign ifc.add_sum  = addFull[31:0];
  assign ifc.add_cout = addFull[32];

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sbQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   rdyCount = 0;

  always @(posedge clock) if (ifc.data_resultRDY) rdyCount++;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    assert (got === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic isMult, input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint q;
    if (isMult) begin
      p = longint'(signed'(a)) * longint'(signed'(b));
      return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = longint'(signed'(a)) / longint'(signed'(b));
    return {1'b0, q[31:0]};
  endfunction

  task automatic applyStimulus(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] er, input logic ee, input int lat, input string tag);
    exp_t e;
    e.res = er; e.exc = ee; e.lat = lat; e.tag = tag;
    sbQ.push_back(e);
    @(negedge clock);
    ifc.ctrl_mult = m;
    ifc.ctrl_div = d;
    ifc.data_operandA = a;
    ifc.data_operandB = b;
    @(posedge clock);
    #1;
    ifc.ctrl_mult = 1'b0;
    ifc.ctrl_div = 1'b0;
  endtask

  task automatic checkOutput(input int busyExp);
    int   n = 0;
    int   busyCnt = 0;
    exp_t e;
    do begin
      @(negedge clock);
      n++;
      if (ifc.busy && !ifc.data_resultRDY) busyCnt++;
    end while (!ifc.data_resultRDY && n < 200);
    testsRun++;
    assert (sbQ.size() != 0) else begin
      testsFailed++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sbQ.pop_front();
    check32({e.tag, " latency"}, 32'(n - 1), 32'(e.lat));
    check32({e.tag, " result"}, ifc.data_result, e.res);
    check32({e.tag, " exception"}, {31'd0, ifc.data_exception}, {31'd0, e.exc});
    if (busyExp >= 0) check32({e.tag, " busy cycles"}, 32'(busyCnt), 32'(busyExp));
    @(negedge clock);
    check32({e.tag, " rdy single"}, {31'd0, ifc.data_resultRDY}, 32'd0);
    check32({e.tag, " result held"}, ifc.data_result, e.res);
  endtask

  initial begin
    logic [32:0] m;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rm;
    int          rdySnap;
    int          div0Lat;
`ifdef MULTDIV_DIV0_FAST_EN
    div0Lat = 1;
`else
    div0Lat = 36;
`endif
    ifc.ctrl_mult = 1'b0;
    ifc.ctrl_div = 1'b0;
    ifc.data_operandA = '0;
    ifc.data_operandB = '0;
    #2;
    check32("reset result", ifc.data_result, 32'd0);
    check32("reset busy", {31'd0, ifc.busy}, 32'd0);
    check32("reset rdy", {31'd0, ifc.data_resultRDY}, 32'd0);
    check32("idle add_a", ifc.add_a, 32'd0);
    check32("idle add_sub", {31'd0, ifc.add_sub}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 36, "mul 7x-6");
    check32("nega add_a", ifc.add_a, 32'd0);
    check32("nega add_b", ifc.add_b, 32'd7);
    check32("nega add_sub", {31'd0, ifc.add_sub}, 32'd1);
    checkOutput(36);

    applyStimulus(1'b1, 1'b0, 32'd65536, 32'd65536, 32'd0, 1'b1, 36, "mul 2^16x2^16");
    checkOutput(-1);
    applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 36, "mul min x1");
    checkOutput(-1);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 36, "div -100/7");
    checkOutput(-1);
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 36, "div min/-1");
    checkOutput(-1);
    applyStimulus(1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1, div0Lat, "div 5/0");
    checkOutput(-1);

    // Abort: multiply started, divide issued ten edges later replaces it.
    rdySnap = rdyCount;
    applyStimulus(1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, 36, "aborted mul");
    repeat (9) @(posedge clock);
    void'(sbQ.pop_front());
    applyStimulus(1'b0, 1'b1, 32'd20, 32'd3, 32'd6, 1'b0, 36, "div 20/3 after abort");
    checkOutput(-1);
    check32("abort rdy count", 32'(rdyCount - rdySnap), 32'd1);

    applyStimulus(1'b1, 1'b1, 32'd3, 32'd4, 32'd12, 1'b0, 36, "both ctrl");
    checkOutput(-1);

    // Asynchronous reset in the middle of a multiply.
    applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 36, "reset victim");
    repeat (19) @(posedge clock);
    #3;
    check32("pre-reset busy", {31'd0, ifc.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    sbQ.delete();
    check32("mid reset result", ifc.data_result, 32'd0);
    check32("mid reset exc", {31'd0, ifc.data_exception}, 32'd0);
    check32("mid reset busy", {31'd0, ifc.busy}, 32'd0);
    check32("mid reset add_b", ifc.add_b, 32'd0);
    check32("mid reset add_sub", {31'd0, ifc.add_sub}, 32'd0);
    rdySnap = rdyCount;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    check32("post reset no rdy", 32'(rdyCount - rdySnap), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd15, 1'b0, 36, "mul after reset");
    checkOutput(36);

    for (int i = 0; i < 4; i++) begin
      rm = i[0];
      ra = $urandom();
      rb = (i < 2) ? ($urandom() & 32'h8000_FFFF) : ($urandom() & 32'hFFFF_0FFF) | 32'd1;
      if (i == 3) ra = ra & 32'h0000_FFFF;
      m = model(rm, ra, rb);
      applyStimulus(rm, !rm, ra, rb, m[31:0], m[32], 36, rm ? "rand mul" : "rand div");
      checkOutput(-1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
